// File: rtl/pipeline_reg_controller.sv
// pipeline_reg_controller
// Load-enable and flush sequencer for the PC and the IF/ID, ID/EX, EX/MEM and
// MEM/WB pipeline registers of the 5-stage core. Resolves halt, memory stalls
// (with a watchdog), taken-branch squashes and load-use hazards.
// Optional feature: define STALL_COUNTER_EN to build the 32-bit stall-cycle
// counter on stall_cnt; otherwise stall_cnt is tied to zero.

module pipeline_reg_controller #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    input  logic                  halt_req,
    output logic                  pc_load,
    output logic                  ifid_load,
    output logic                  idex_load,
    output logic                  exmem_load,
    output logic                  memwb_load,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  halted,
    output logic                  mem_timeout_err,
    output logic [31:0]           stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] LP_TIMEOUT = TO_W'(MEM_TIMEOUT);

    state_t          r_state;
    state_t          w_state_next;
    logic [TO_W-1:0] r_wd_cnt;
    logic [TO_W-1:0] w_wd_next;
    logic [TO_W-1:0] w_wd_inc;
    logic            r_timeout_err;
    logic            w_err_set;
    logic            w_load_use;

    // Watchdog increment saturates at all-ones so it can never wrap to zero.
    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        return (v == {TO_W{1'b1}}) ? v : v + TO_W'(1);
    endfunction

    assign w_wd_inc   = sat_inc(r_wd_cnt);
    // x0 is hard-wired zero, so a load targeting it can never create a hazard.
    assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign mem_timeout_err = r_timeout_err;

    // Next-state and output decode; outputs depend only on state and inputs.
    always_comb begin
        pc_load      = 1'b0;
        ifid_load    = 1'b0;
        idex_load    = 1'b0;
        exmem_load   = 1'b0;
        memwb_load   = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        halted       = 1'b0;
        w_state_next = r_state;
        w_wd_next    = r_wd_cnt;
        w_err_set    = 1'b0;

        if (!rst) begin
            case (r_state)
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    if (halt_req) begin
                        w_state_next = HALT;
                    end else if (mem_busy) begin
                        // Full freeze while the data memory is busy.
                        w_wd_next = w_wd_inc;
                        if (w_wd_inc >= LP_TIMEOUT) begin
                            w_state_next = HALT;
                            w_err_set    = 1'b1;
                        end else begin
                            w_state_next = WAIT_MEM;
                        end
                    end else begin
                        w_state_next = RUN;
                        w_wd_next    = '0;
                        if (branch_taken) begin
                            // Squash wins over load-use: the dependent
                            // instruction in ID is discarded anyway.
                            pc_load    = 1'b1;
                            ifid_load  = 1'b1;
                            idex_load  = 1'b1;
                            exmem_load = 1'b1;
                            memwb_load = 1'b1;
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (w_load_use) begin
                            // Hold PC and IF/ID, inject a bubble into ID/EX.
                            idex_load  = 1'b1;
                            idex_flush = 1'b1;
                            exmem_load = 1'b1;
                            memwb_load = 1'b1;
                        end else begin
                            pc_load    = 1'b1;
                            ifid_load  = 1'b1;
                            idex_load  = 1'b1;
                            exmem_load = 1'b1;
                            memwb_load = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // State, watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_wd_cnt <= w_wd_next;
            if (w_err_set) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

`ifdef STALL_COUNTER_EN
    logic [31:0] r_stall_cnt;

    // Count every non-halted cycle in which the PC is held; wraps mod 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!pc_load && (r_state != HALT)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_reg_controller.sv
// Testbench for pipeline_reg_controller: directed vector table, hand-written
// multi-cycle sequences (reset, memory stall, watchdog, halt) and randomized
// stimulus checked against a behavioural model of the controller rules.

module tb_pipeline_reg_controller;

    localparam int REG_ADDR_W  = 5;
    localparam int MEM_TIMEOUT = 16;
    localparam int TO_W        = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
    logic                  ex_mem_read, branch_taken, mem_busy, halt_req;
    logic                  pc_load, ifid_load, idex_load, exmem_load, memwb_load;
    logic                  ifid_flush, idex_flush, halted, mem_timeout_err;
    logic [31:0]           stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic        m_halted = 1'b0;
    logic        m_err    = 1'b0;
    int          m_busy_run = 0;
    logic [31:0] m_stall  = '0;

    pipeline_reg_controller #(
        .REG_ADDR_W (REG_ADDR_W),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TO_W       (TO_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .branch_taken   (branch_taken),
        .mem_busy       (mem_busy),
        .halt_req       (halt_req),
        .pc_load        (pc_load),
        .ifid_load      (ifid_load),
        .idex_load      (idex_load),
        .exmem_load     (exmem_load),
        .memwb_load     (memwb_load),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .halted         (halted),
        .mem_timeout_err(mem_timeout_err),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    logic [8:0] w_vec;
    assign w_vec = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                    ifid_flush, idex_flush, halted, mem_timeout_err};

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       busy;
        logic [6:0] exp;   // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected {loads, flushes, halted, err} from the controller rules.
    function automatic logic [8:0] model_out();
        logic lu;
        lu = ex_mem_read && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (rst)                   return {7'b0000000, 1'b0, m_err};
        if (m_halted)              return {7'b0000000, 1'b1, m_err};
        if (halt_req || mem_busy)  return {7'b0000000, 1'b0, m_err};
        if (branch_taken)          return {7'b1111111, 1'b0, m_err};
        if (lu)                    return {7'b0011101, 1'b0, m_err};
        return {7'b1111100, 1'b0, m_err};
    endfunction

    function automatic logic [31:0] exp_stall();
`ifdef STALL_COUNTER_EN
        return m_stall;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_step(input logic pc_exp);
        if (rst) begin
            m_halted   = 1'b0;
            m_err      = 1'b0;
            m_busy_run = 0;
            m_stall    = '0;
        end else if (!m_halted) begin
            if (!pc_exp) m_stall = m_stall + 32'd1;
            if (halt_req) begin
                m_halted = 1'b1;
            end else if (mem_busy) begin
                m_busy_run++;
                if (m_busy_run >= MEM_TIMEOUT) begin
                    m_halted = 1'b1;
                    m_err    = 1'b1;
                end
            end else begin
                m_busy_run = 0;
            end
        end
    endtask

    // Check current outputs against the model, then advance one clock.
    task automatic cycle_check(input string name);
        logic [8:0] e;
        e = model_out();
        #3;
        chk({name, " ctl"}, 32'(w_vec), 32'(e));
        chk({name, " stall_cnt"}, stall_cnt, exp_stall());
        @(posedge clk);
        model_step(e[8]);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        ex_mem_read = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic prev_busy;
        tbl[0] = '{5'd1,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 7'b0011101};
        tbl[1] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 7'b1111100};
        tbl[2] = '{5'd7,  5'd2,  5'd7,  1'b0, 1'b0, 1'b0, 7'b1111100};
        tbl[3] = '{5'd3,  5'd9,  5'd3,  1'b1, 1'b1, 1'b0, 7'b1111111};
        tbl[4] = '{5'd4,  5'd6,  5'd8,  1'b1, 1'b0, 1'b0, 7'b1111100};
        tbl[5] = '{5'd12, 5'd1,  5'd12, 1'b1, 1'b0, 1'b0, 7'b0011101};
        tbl[6] = '{5'd12, 5'd1,  5'd12, 1'b1, 1'b0, 1'b1, 7'b0000000};
        tbl[7] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 7'b1111111};
        tbl[8] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 7'b0011101};

        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        model_step(1'b0);
        #1;

        // Reset held, then idle
        cycle_check("rst0");
        cycle_check("rst1");
        rst = 1'b0;
        #2;
        chk("idle_loads", 32'({pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                               ifid_flush, idex_flush, halted}), 32'h0F8);
        cycle_check("idle");

        // Directed priority table
        for (int i = 0; i < 9; i++) begin
            id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd;
            ex_mem_read = tbl[i].mr; branch_taken = tbl[i].br; mem_busy = tbl[i].busy;
            #2;
            chk($sformatf("vec%0d table", i),
                32'({pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                     ifid_flush, idex_flush}), 32'(tbl[i].exp));
            cycle_check($sformatf("vec%0d", i));
        end
        idle_inputs();

        // Four-cycle memory stall
        rst = 1'b1; cycle_check("mst_rst"); rst = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) cycle_check($sformatf("mst_busy%0d", i));
        mem_busy = 1'b0;
        cycle_check("mst_release");
`ifdef STALL_COUNTER_EN
        chk("mst_stall4", stall_cnt, 32'd4);
`else
        chk("mst_stall0", stall_cnt, 32'd0);
`endif

        // Watchdog timeout
        rst = 1'b1; cycle_check("wd_rst"); rst = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT; i++) cycle_check($sformatf("wd_busy%0d", i));
        #2;
        chk("wd_halted", 32'(halted), 32'd1);
        chk("wd_err", 32'(mem_timeout_err), 32'd1);
        mem_busy = 1'b0;
        cycle_check("wd_drop0");
        cycle_check("wd_drop1");
        rst = 1'b1; cycle_check("wd_clr"); rst = 1'b0;
        #2;
        chk("wd_clr_halted", 32'(halted), 32'd0);
        chk("wd_clr_err", 32'(mem_timeout_err), 32'd0);

        // Halt during a taken branch, then branch toggling while halted
        halt_req = 1'b1; branch_taken = 1'b1;
        cycle_check("halt_req");
        halt_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            branch_taken = i[0];
            #2;
            chk($sformatf("halt_hold%0d", i), 32'({halted, pc_load}), 32'd2);
            cycle_check($sformatf("halt_cyc%0d", i));
        end
        rst = 1'b1; cycle_check("halt_rst"); rst = 1'b0;
        idle_inputs();

        // Randomized stimulus against the model
        prev_busy = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 59) == 0);
            halt_req     = ($urandom_range(0, 49) == 0);
            mem_busy     = prev_busy ? ($urandom_range(0, 9) != 0)
                                     : ($urandom_range(0, 9) < 2);
            prev_busy    = mem_busy;
            branch_taken = ($urandom_range(0, 3) == 0);
            ex_mem_read  = $urandom_range(0, 1) == 1;
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            cycle_check($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
